// File: rtl/cordic_pkg.sv
// Shared definitions for the vectoring CORDIC direction generator: FSM encoding,
// direction-bit convention and the gain-compensation shift/sign set.
package cordic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_ITER = 3'd2,
        ST_COMP = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // dir = 0 when y >= 0 (clockwise step), 1 when y < 0
    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    // K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 = 0.607422; bit k of GC_NEG marks a subtracted term
    localparam int         GC_N             = 4;
    localparam int         GC_SHIFT [GC_N]  = '{1, 3, 6, 9};
    localparam logic [3:0] GC_NEG           = 4'b1100;

endpackage

// File: rtl/cordic_vec_microrot.sv
// One vectoring-mode CORDIC micro-rotation: picks the direction from sign(y)
// and applies the arithmetic-shift add/sub pair.
module cordic_vec_microrot
    import cordic_pkg::*;
#(
    parameter int W  = 24,
    parameter int SW = 4
) (
    input  logic signed [W-1:0]  x_i,
    input  logic signed [W-1:0]  y_i,
    input  logic        [SW-1:0] shift_i,
    output logic signed [W-1:0]  x_o,
    output logic signed [W-1:0]  y_o,
    output logic                 dir_o
);

    logic signed [W-1:0] xs_s;
    logic signed [W-1:0] ys_s;

    // Shift-and-add step steering y toward zero
    always_comb begin
        xs_s = x_i >>> shift_i;
        ys_s = y_i >>> shift_i;
        if (y_i[W-1] == 1'b0) begin
            dir_o = DIR_CW;
            x_o   = x_i + ys_s;
            y_o   = y_i - xs_s;
        end else begin
            dir_o = DIR_CCW;
            x_o   = x_i - ys_s;
            y_o   = y_i + xs_s;
        end
    end

endmodule

// File: rtl/cordic_vec_dir_gen.sv
// Iterative vectoring CORDIC producing the microRot_dir word and scaled magnitude.
// Optional COMP state (gain compensation) enabled by CORDIC_VEC_GAIN_COMP_EN.
module cordic_vec_dir_gen
    import cordic_pkg::*;
#(
    parameter int CORDIC_WIDTH = 22,
    parameter int N_ITER       = 16,
    parameter int GW           = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CORDIC_WIDTH-1:0]      x_in,
    input  logic [CORDIC_WIDTH-1:0]      y_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_ITER-1:0]            microRot_dir,
    output logic                         quad_flip,
    output logic [CORDIC_WIDTH+GW-1:0]   mag_out
);

    localparam int W  = CORDIC_WIDTH + GW;
    localparam int SW = (N_ITER > 1) ? $clog2(N_ITER) : 1;

    state_e              state_q;
    logic signed [W-1:0] x_q;
    logic signed [W-1:0] y_q;
    logic [SW-1:0]       i_q;
    logic [N_ITER-1:0]   dir_q;
    logic                quad_flip_q;
    logic                in_ready_q;
    logic                out_valid_q;

    logic signed [W-1:0] rot_x_s;
    logic signed [W-1:0] rot_y_s;
    logic                rot_dir_s;

    cordic_vec_microrot #(.W(W), .SW(SW)) u_microrot (
        .x_i     (x_q),
        .y_i     (y_q),
        .shift_i (i_q),
        .x_o     (rot_x_s),
        .y_o     (rot_y_s),
        .dir_o   (rot_dir_s)
    );

`ifdef CORDIC_VEC_GAIN_COMP_EN
    logic signed [W-1:0] comp_x_s;

    // Constant-gain multiply by K built from the shared shift/sign set
    always_comb begin
        comp_x_s = {W{1'b0}};
        for (int k = 0; k < GC_N; k++) begin
            if (GC_NEG[k]) begin
                comp_x_s = comp_x_s - (x_q >>> GC_SHIFT[k]);
            end else begin
                comp_x_s = comp_x_s + (x_q >>> GC_SHIFT[k]);
            end
        end
    end
`endif

    // Control FSM with datapath registers; out_valid rises one cycle after entering DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            x_q         <= {W{1'b0}};
            y_q         <= {W{1'b0}};
            i_q         <= {SW{1'b0}};
            dir_q       <= {N_ITER{1'b0}};
            quad_flip_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_q        <= {{GW{x_in[CORDIC_WIDTH-1]}}, x_in};
                        y_q        <= {{GW{y_in[CORDIC_WIDTH-1]}}, y_in};
                        dir_q      <= {N_ITER{1'b0}};
                        in_ready_q <= 1'b0;
                        state_q    <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (x_q[W-1]) begin
                        x_q         <= -x_q;
                        y_q         <= -y_q;
                        quad_flip_q <= 1'b1;
                    end else begin
                        quad_flip_q <= 1'b0;
                    end
                    i_q     <= {SW{1'b0}};
                    state_q <= ST_ITER;
                end
                ST_ITER: begin
                    x_q        <= rot_x_s;
                    y_q        <= rot_y_s;
                    dir_q[i_q] <= rot_dir_s;
                    i_q        <= i_q + SW'(1);
                    if (i_q == SW'(N_ITER - 1)) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                        state_q <= ST_COMP;
`else
                        state_q <= ST_DONE;
`endif
                    end
                end
`ifdef CORDIC_VEC_GAIN_COMP_EN
                ST_COMP: begin
                    x_q     <= comp_x_s;
                    state_q <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign microRot_dir = dir_q;
    assign quad_flip    = quad_flip_q;
    assign mag_out      = x_q;

endmodule
